// File: rtl/ex_cond_unit.sv
// rtl/ex_cond_unit.sv - execute-stage PA-RISC condition evaluation, PSW carry and nullify tracking
module ex_cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_alu_out,
    input  logic [3:0]       i_alu_flags,
    input  logic             i_ex_valid,
    input  logic [2:0]       i_cond,
    input  logic             i_cond_neg,
    input  logic             i_cond_en,
    input  logic             i_carry_we,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic             o_ci,
    output logic             o_cond_true,
    output logic             o_nullify_ex,
    output logic [CNT_W-1:0] o_null_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_ci;
    logic [CNT_W-1:0] r_null_cnt;

    logic w_z, w_n, w_c, w_v;
    logic w_raw;
    logic w_pend;
    logic w_adv;
    logic w_eff;
    logic w_set_pend;
    logic w_cnt_sat;
    logic w_unused_out;

    assign w_z = i_alu_flags[3];
    assign w_n = i_alu_flags[2];
    assign w_c = i_alu_flags[1];
    assign w_v = i_alu_flags[0];

    assign w_unused_out = ^i_alu_out[31:1];

    always_comb begin
        w_raw = 1'b0;
        case (i_cond)
            3'b000: w_raw = 1'b0;
            3'b001: w_raw = w_z;
            3'b010: w_raw = w_n ^ w_v;
            3'b011: w_raw = (w_n ^ w_v) | w_z;
            3'b100: w_raw = ~w_c;
            3'b101: w_raw = ~w_c | w_z;
            3'b110: w_raw = w_v;
            3'b111: w_raw = i_alu_out[0];
            default: w_raw = 1'b0;
        endcase
    end

    assign o_cond_true = w_raw ^ i_cond_neg;

    // adv: instruction leaves EX this edge; eff: it leaves and actually executes.
    assign w_adv      = i_ex_valid & ~i_stall & ~i_flush;
    assign w_eff      = w_adv & ~o_nullify_ex;
    assign w_set_pend = w_eff & i_cond_en & o_cond_true;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bubbles hold PEND so the nullification lands on the next real instruction.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_set_pend) begin
                    w_next_state = S_PEND;
                end
            end
            S_PEND: begin
                if (i_flush || w_adv) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_pend       = (r_state == S_PEND);
        o_nullify_ex = w_pend & i_ex_valid;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ci <= 1'b0;
        end else if (w_eff && i_carry_we) begin
            r_ci <= w_c;
        end
    end

    assign w_cnt_sat = &r_null_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_null_cnt <= '0;
        end else if (w_adv && o_nullify_ex && !w_cnt_sat) begin
            r_null_cnt <= r_null_cnt + CNT_W'(1);
        end
    end

    assign o_ci       = r_ci;
    assign o_null_cnt = r_null_cnt;

endmodule

// File: tb/tb_ex_cond_unit.sv
// tb/tb_ex_cond_unit.sv - self-checking bench for ex_cond_unit with a behavioural reference model
module tb_ex_cond_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_out;
    logic [3:0]  alu_flags;
    logic        ex_valid, cond_neg, cond_en, carry_we, stall, flush;
    logic [2:0]  cond;

    logic        ci_a, ct_a, nx_a;
    logic [15:0] cnt_a;
    logic        ci_b, ct_b, nx_b;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    ex_cond_unit #(.CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_alu_out(alu_out), .i_alu_flags(alu_flags),
        .i_ex_valid(ex_valid), .i_cond(cond), .i_cond_neg(cond_neg), .i_cond_en(cond_en),
        .i_carry_we(carry_we), .i_stall(stall), .i_flush(flush),
        .o_ci(ci_a), .o_cond_true(ct_a), .o_nullify_ex(nx_a), .o_null_cnt(cnt_a)
    );

    ex_cond_unit #(.CNT_W(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_alu_out(alu_out), .i_alu_flags(alu_flags),
        .i_ex_valid(ex_valid), .i_cond(cond), .i_cond_neg(cond_neg), .i_cond_en(cond_en),
        .i_carry_we(carry_we), .i_stall(stall), .i_flush(flush),
        .o_ci(ci_b), .o_cond_true(ct_b), .o_nullify_ex(nx_b), .o_null_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: condition table from flag names, pending flag, carry and counters.
    function automatic logic model_cond(input logic [2:0] c, input logic neg,
                                        input logic [3:0] f, input logic [31:0] o);
        logic z, n, cy, v, r;
        z = f[3]; n = f[2]; cy = f[1]; v = f[0];
        case (c)
            3'd0: r = 1'b0;
            3'd1: r = z;
            3'd2: r = (n != v);
            3'd3: r = (n != v) || z;
            3'd4: r = !cy;
            3'd5: r = !cy || z;
            3'd6: r = v;
            default: r = o[0];
        endcase
        return r ^ neg;
    endfunction

    bit m_pend;
    bit m_ci;
    int m_cnt16;
    int m_cnt2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  = 0;
            m_ci    = 0;
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else begin
            bit nulled, retires, executes;
            nulled   = m_pend && ex_valid;
            retires  = ex_valid && !stall && !flush;
            executes = retires && !nulled;
            if (executes && carry_we) m_ci = alu_flags[1];
            if (retires && nulled) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (m_pend) begin
                if (retires || flush) m_pend = 0;
            end else if (executes && cond_en && model_cond(cond, cond_neg, alu_flags, alu_out)) begin
                m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_ct, exp_nx;
        exp_ct = model_cond(cond, cond_neg, alu_flags, alu_out);
        exp_nx = m_pend && ex_valid;
        chk("model_ci_a", {31'd0, ci_a}, {31'd0, m_ci});
        chk("model_ct_a", {31'd0, ct_a}, {31'd0, exp_ct});
        chk("model_nx_a", {31'd0, nx_a}, {31'd0, exp_nx});
        chk("model_cnt_a", {16'd0, cnt_a}, m_cnt16);
        chk("model_ci_b", {31'd0, ci_b}, {31'd0, m_ci});
        chk("model_nx_b", {31'd0, nx_b}, {31'd0, exp_nx});
        chk("model_cnt_b", {30'd0, cnt_b}, m_cnt2);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic neg, input logic en,
                         input logic cwe, input logic [3:0] f);
        ex_valid = v; cond = c; cond_neg = neg; cond_en = en; carry_we = cwe; alu_flags = f;
        stall = 0; flush = 0;
    endtask

    task automatic set_pend();
        drive(1, 3'b001, 0, 1, 0, 4'b1000);
        step();
    endtask

    logic [7:0] sweep_exp;
    logic [1:0] sat_exp [5];

    initial begin
        sweep_exp = 8'b1111_0000;
        sat_exp   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        alu_out = 32'h0;
        rst_n = 0;
        drive(1, 3'b000, 0, 0, 1, 4'b0010);
        repeat (2) @(posedge clk);
        #2;
        chk("reset_ci", {31'd0, ci_a}, 32'd0);
        chk("reset_cnt", {16'd0, cnt_a}, 32'd0);
        chk("reset_nx", {31'd0, nx_a}, 32'd0);
        rst_n = 1;
        step();
        chk("first_edge_ci", {31'd0, ci_a}, 32'd1);

        drive(0, 3'b000, 0, 0, 0, 4'b0101);
        alu_out = 32'h0000_0039;
        for (int i = 0; i < 8; i++) begin
            for (int ng = 0; ng < 2; ng++) begin
                logic [7:0] tbl;
                cond = 3'(i);
                cond_neg = ng[0];
                #1;
                tbl = sweep_exp;
                chk($sformatf("sweep_c%0d_n%0d", i, ng), {31'd0, ct_a},
                    {31'd0, tbl[i] ^ ng[0]});
            end
        end
        step();

        drive(1, 3'b000, 0, 0, 1, 4'b0000);
        step();
        chk("ci_cleared", {31'd0, ci_a}, 32'd0);
        set_pend();
        drive(0, 3'b000, 0, 0, 0, 4'b0000);
        #1 chk("bubble_nx", {31'd0, nx_a}, 32'd0);
        step();
        drive(1, 3'b000, 0, 0, 1, 4'b0010);
        #1 chk("i1_nx", {31'd0, nx_a}, 32'd1);
        step();
        drive(1, 3'b000, 0, 0, 0, 4'b0000);
        #1;
        chk("i2_nx", {31'd0, nx_a}, 32'd0);
        chk("chain_ci", {31'd0, ci_a}, 32'd0);
        chk("chain_cnt", {16'd0, cnt_a}, 32'd1);
        step();

        set_pend();
        drive(1, 3'b000, 1, 1, 0, 4'b0000);
        #1;
        chk("null_true_nx", {31'd0, nx_a}, 32'd1);
        chk("null_true_ct", {31'd0, ct_a}, 32'd1);
        step();
        drive(1, 3'b000, 0, 0, 0, 4'b0000);
        #1;
        chk("null_true_i2", {31'd0, nx_a}, 32'd0);
        chk("null_true_cnt", {16'd0, cnt_a}, 32'd2);
        step();

        set_pend();
        drive(1, 3'b000, 0, 0, 1, 4'b0010);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_nx", k), {31'd0, nx_a}, 32'd1);
            chk($sformatf("stall%0d_cnt", k), {16'd0, cnt_a}, 32'd2);
            step();
        end
        flush = 1;
        step();
        drive(1, 3'b000, 0, 0, 0, 4'b0000);
        #1;
        chk("flush_nx", {31'd0, nx_a}, 32'd0);
        chk("flush_cnt", {16'd0, cnt_a}, 32'd2);
        chk("flush_ci", {31'd0, ci_a}, 32'd0);
        step();

        rst_n = 0;
        #2;
        chk("async_rst_cnt", {16'd0, cnt_a}, 32'd0);
        rst_n = 1;
        step();
        for (int k = 0; k < 5; k++) begin
            set_pend();
            drive(1, 3'b000, 0, 0, 0, 4'b0000);
            step();
            chk($sformatf("sat%0d_cnt2", k), {30'd0, cnt_b}, {30'd0, sat_exp[k]});
            chk($sformatf("sat%0d_cnt16", k), {16'd0, cnt_a}, 32'(k + 1));
        end

        drive(0, 3'b000, 0, 0, 0, 4'b0000);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
